// File: rtl/tau_mac_pkg.sv
// Shared types for the tau_mac round-robin scheduler.
// Scheduler states and default operand/accumulator widths.
package tau_mac_pkg;

  localparam int BITWIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF = 2 * BITWIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tau_rr_arbiter.sv
// Round-robin pick: first set request after last_i, with wrap.
// Produces a one-hot grant, its index and an any-request flag.
module tau_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  // Scan NUM_REQ slots starting just past the previous winner
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    gnt_o = '0;
    id_o  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/tau_mac_sched.sv
// Round-robin scheduler sharing one tau_mac among NUM_REQ requesters.
// Optional WAIT watchdog and DRAIN state: TAU_MAC_SCHED_TIMEOUT_EN.
module tau_mac_sched
  import tau_mac_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BITWIDTH       = BITWIDTH_DEF,
  parameter int OUT_WIDTH      = 2 * BITWIDTH,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [OUT_WIDTH-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         mac_start,
  output logic [BITWIDTH-1:0]          mac_a,
  output logic [BITWIDTH-1:0]          mac_b,
  input  logic                         mac_valid,
  input  logic [OUT_WIDTH-1:0]         mac,
  output logic                         busy
);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      last_q, id_q, rsp_id_q;
  logic [BITWIDTH-1:0]  a_q, b_q, a_sel, b_sel;
  logic [OUT_WIDTH-1:0] base_q, rsp_data_q;
  logic                 seen_low_q, rsp_err_q;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any, hs, done, tmo;

  tau_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .id_o   (gnt_id),
    .any_o  (gnt_any)
  );

  // Accept only in IDLE; held low while reset is asserted
  assign req_ready = (state_q == IDLE && !reset && gnt_any) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  // A level still high from the previous job must fall first
  assign done      = mac_valid & seen_low_q;

  // One-hot operand mux for the granted requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_sel | req_a[i*BITWIDTH +: BITWIDTH];
        b_sel = b_sel | req_b[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

`ifdef TAU_MAC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  assign tmo = (state_q == WAIT) && !done &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared in ISSUE, counts every WAIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_q <= '0;
    else if (state_q == ISSUE) cnt_q <= '0;
    else if (state_q == WAIT)  cnt_q <= cnt_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (hs) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (done || tmo) state_d = RESP;
`ifdef TAU_MAC_SCHED_TIMEOUT_EN
      RESP:  if (rsp_ready) state_d = rsp_err_q ? DRAIN : IDLE;
      DRAIN: if (done) state_d = IDLE;
`else
      RESP:  if (rsp_ready) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, job capture, low-seen tracking and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      base_q     <= '0;
      seen_low_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (hs) begin
          a_q        <= a_sel;
          b_q        <= b_sel;
          id_q       <= gnt_id;
          base_q     <= mac;
          seen_low_q <= 1'b0;
        end
        WAIT: begin
          if (!mac_valid) seen_low_q <= 1'b1;
          if (done) begin
            rsp_data_q <= mac - base_q;
            rsp_id_q   <= id_q;
            rsp_err_q  <= 1'b0;
          end else if (tmo) begin
            rsp_data_q <= '0;
            rsp_id_q   <= id_q;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP:  if (rsp_ready) last_q <= id_q;
        DRAIN: if (!mac_valid) seen_low_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mac_start = (state_q == ISSUE);
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tau_mac_sched.sv
// Directed bench for tau_mac_sched with a tau_mac stub and scoreboard.
// Watchdog steps run when TAU_MAC_SCHED_TIMEOUT_EN is defined.
module tb_tau_mac_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err, mac_start, busy;
  logic [7:0]  mac_a, mac_b;

  // tau_mac stub state and controls
  logic [15:0] stub_mac = '0;
  logic        stub_valid = 1'b0;
  logic        stub_run = 1'b0;
  int          stub_cnt = 0;
  int          hold = 1;
  bit          silent = 0, kick = 0, set_mac = 0;
  logic [15:0] set_val = '0;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int   glog[$];

  int  checks = 0, errors = 0;
  int  ncyc = 0, nrsp = 0, nstart = 0, hs_cyc = -10;
  bit  prev_start = 0, expect_tmo = 0;

  tau_mac_sched #(
    .NUM_REQ(4), .BITWIDTH(8), .OUT_WIDTH(16), .ID_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(stub_valid), .mac(stub_mac), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub: mac += a*b and mac_valid rises 5 cycles after start, then held
  always @(posedge clk) begin
    if (set_mac) stub_mac <= set_val;
    if (mac_start) begin
      if (silent) begin
        stub_valid <= 1'b0;
        stub_run   <= 1'b0;
      end else begin
        stub_run <= 1'b1;
        stub_cnt <= 1;
      end
    end else if (kick) begin
      stub_run <= 1'b1;
      stub_cnt <= 1;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == hold) stub_valid <= 1'b0;
      if (stub_cnt == 5) begin
        stub_valid <= 1'b1;
        stub_mac   <= stub_mac + 16'(mac_a) * 16'(mac_b);
        stub_run   <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, run monitors, return after posedge
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    ncyc++;
    check("rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
    if (req_ready != 0) check("rdy_only_idle", 32'(busy), 32'd0);
    if (mac_start) begin
      nstart++;
      check("start_pulse", 32'(prev_start), 32'd0);
      check("start_lat", 32'(ncyc), 32'(hs_cyc + 1));
    end
    prev_start = mac_start;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i;
        e.data = expect_tmo ? 16'd0 :
                 16'(req_a[i*8 +: 8]) * 16'(req_b[i*8 +: 8]);
        e.err  = expect_tmo;
        sb.push_back(e);
        glog.push_back(i);
        hs_cyc = ncyc;
      end
    end
    if (rsp_valid && rsp_ready) begin
      nrsp++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int target, k;
    target = nrsp + n;
    k = 0;
    while (nrsp < target && k < budget) begin
      cyc();
      k++;
    end
    check("rsp_count", 32'(nrsp), 32'(target));
  endtask

  task automatic wait_hs(input int budget);
    int target, k;
    target = glog.size() + 1;
    k = 0;
    while (glog.size() < target && k < budget) begin
      cyc();
      k++;
    end
    check("grant_seen", 32'(glog.size()), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (10) cyc();
    reset = 1'b0;
    sb.delete();
    glog.delete();
    cyc();
  endtask

  initial begin
    int s0;
    // Reset values, with requests pending to prove req_ready is masked
    req_valid = 4'b1111;
    #1 reset = 1'b1;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rvalid", 32'(rsp_valid), 32'd0);
    check("rst_start", 32'(mac_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a", 32'(mac_a), 32'd0);
    check("rst_b", 32'(mac_b), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    do_reset();

    // 1. single job from requester 0
    req_a = 32'h0000_0003;
    req_b = 32'h0000_0004;
    req_valid = 4'b0001;
    s0 = nstart;
    wait_hs(10);
    req_valid = '0;
    wait_rsp(1, 50);
    check("t1_starts", 32'(nstart - s0), 32'd1);

    // 2. all requesters held: order 0,1,2,3,0 from reset
    do_reset();
    req_a = {8'd40, 8'd30, 8'd20, 8'd10};
    req_b = {8'd200, 8'd3, 8'd255, 8'd7};
    req_valid = 4'b1111;
    wait_rsp(5, 200);
    req_valid = '0;
    check("t2_glen", 32'(glog.size()), 32'd5);
    if (glog.size() == 5) begin
      check("t2_g0", 32'(glog[0]), 32'd0);
      check("t2_g1", 32'(glog[1]), 32'd1);
      check("t2_g2", 32'(glog[2]), 32'd2);
      check("t2_g3", 32'(glog[3]), 32'd3);
      check("t2_g4", 32'(glog[4]), 32'd0);
    end

    // 3. accumulator wrap: 0xFFFA + 10 -> 0x0004, delta 10
    set_val = 16'hFFFA;
    set_mac = 1;
    cyc();
    set_mac = 0;
    req_a = 32'h0002_0000;
    req_b = 32'h0005_0000;
    req_valid = 4'b0100;
    wait_hs(10);
    req_valid = '0;
    wait_rsp(1, 50);

    // 4. response back-pressure with a request arriving in RESP
    rsp_ready = 1'b0;
    req_a = {8'd11, 8'd0, 8'd7, 8'd0};
    req_b = {8'd13, 8'd0, 8'd9, 8'd0};
    req_valid = 4'b0010;
    for (int k = 0; k < 50 && !rsp_valid; k++) cyc();
    check("t4_rvalid", 32'(rsp_valid), 32'd1);
    req_valid = 4'b1000;
    s0 = nstart;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("t4_hold_v", 32'(rsp_valid), 32'd1);
      check("t4_ready0", 32'(req_ready), 32'd0);
      if (sb.size() != 0) begin
        check("t4_hold_id", 32'(rsp_id), 32'(sb[0].id));
        check("t4_hold_d", 32'(rsp_data), 32'(sb[0].data));
      end
    end
    check("t4_nostart", 32'(nstart - s0), 32'd0);
    rsp_ready = 1'b1;
    wait_rsp(1, 10);
    wait_hs(10);
    req_valid = '0;
    wait_rsp(1, 50);

    // 5. mac_valid still high through ISSUE and early WAIT
    hold = 3;
    check("t5_held", 32'(stub_valid), 32'd1);
    req_a = 32'h0000_0005;
    req_b = 32'h0000_0006;
    req_valid = 4'b0001;
    wait_hs(10);
    req_valid = '0;
    wait_rsp(1, 50);
    hold = 1;

    // 6. asynchronous reset while in WAIT, then req0 wins first
    req_a = 32'h0000_0900;
    req_b = 32'h0000_0300;
    req_valid = 4'b0010;
    wait_hs(10);
    req_valid = '0;
    cyc();
    cyc();
    check("t6_busy", 32'(busy), 32'd1);
    req_valid = 4'b0111;
    #2 reset = 1'b1;
    #1;
    check("t6_busy0", 32'(busy), 32'd0);
    check("t6_a0", 32'(mac_a), 32'd0);
    check("t6_rdy0", 32'(req_ready), 32'd0);
    check("t6_rv0", 32'(rsp_valid), 32'd0);
    check("t6_st0", 32'(mac_start), 32'd0);
    sb.delete();
    glog.delete();
    repeat (10) cyc();
    reset = 1'b0;
    req_a = {8'd0, 8'd4, 8'd3, 8'd2};
    req_b = {8'd0, 8'd5, 8'd6, 8'd7};
    wait_rsp(3, 100);
    req_valid = '0;
    if (glog.size() != 0) check("t6_first", 32'(glog[0]), 32'd0);

`ifdef TAU_MAC_SCHED_TIMEOUT_EN
    // Watchdog: silent stub times out, DRAIN blocks grants until mac_valid
    silent = 1;
    expect_tmo = 1;
    req_a = 32'h0000_0009;
    req_b = 32'h0000_0009;
    req_valid = 4'b0001;
    wait_hs(10);
    expect_tmo = 0;
    req_valid = '0;
    wait_rsp(1, 40);
    req_a = 32'h0000_0200;
    req_b = 32'h0000_0300;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("tmo_drain_rdy", 32'(req_ready), 32'd0);
      check("tmo_drain_busy", 32'(busy), 32'd1);
    end
    silent = 0;
    kick = 1;
    cyc();
    kick = 0;
    wait_hs(30);
    req_valid = '0;
    wait_rsp(1, 50);
`endif

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
